// File: rtl/cim_axi_pkg.sv
// Shared register map, response codes and read-FSM state type for the CIM
// result read-back path.
package cim_axi_pkg;

  localparam int REG_STATUS      = 'h00;
  localparam int REG_CAP_COUNT   = 'h04;
  localparam int REG_RESULT_BASE = 'h08;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/cim_done_capture.sv
// Per-stack done rising-edge detection, result latching, sticky valid/overrun
// status and a wrapping capture counter.
module cim_done_capture #(
  parameter int NUM_STACKS   = 8,
  parameter int RESULT_WIDTH = 15
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_STACKS-1:0]              done,
  input  logic [NUM_STACKS*RESULT_WIDTH-1:0] stage_4_out,
  input  logic [NUM_STACKS-1:0]              clr_valid,
  input  logic                               clr_overrun,
  output logic [NUM_STACKS*RESULT_WIDTH-1:0] result,
  output logic [NUM_STACKS-1:0]              valid,
  output logic [NUM_STACKS-1:0]              overrun,
  output logic [31:0]                        cap_count
);

  logic [NUM_STACKS-1:0] done_q;
  logic [NUM_STACKS-1:0] rise;

  assign rise = done & ~done_q;

  // A capture outranks a clear arriving in the same cycle, so a fresh result
  // is never lost to a read that raced it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= '0;
      // NOTE: the result bank is reset too, so a stack that never finished
      // reads back as zero instead of power-up garbage.
      result    <= '0;
      valid     <= '0;
      overrun   <= '0;
      cap_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples the
      // pre-edge values of its neighbours (overrun uses the old valid).
      done_q    <= done;
      valid     <= rise | (valid & ~clr_valid);
      overrun   <= (clr_overrun ? '0 : overrun) | (rise & valid);
      cap_count <= cap_count + 32'($countones(rise));
      for (int i = 0; i < NUM_STACKS; i++) begin
        if (rise[i]) result[i*RESULT_WIDTH +: RESULT_WIDTH] <= stage_4_out[i*RESULT_WIDTH +: RESULT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/cim_result_reader.sv
// AXI4-Lite read-only responder returning captured CIM stack results, status
// and capture count; irq flags any unread result.
module cim_result_reader
  import cim_axi_pkg::*;
#(
  parameter int NUM_STACKS   = 8,
  parameter int RESULT_WIDTH = 15,
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_STACKS-1:0]              done,
  input  logic [NUM_STACKS*RESULT_WIDTH-1:0] stage_4_out,
  input  logic [ADDR_WIDTH-1:0]              s_axi_araddr,
  input  logic                               s_axi_arvalid,
  output logic                               s_axi_arready,
  output logic [DATA_WIDTH-1:0]              s_axi_rdata,
  output logic [1:0]                         s_axi_rresp,
  output logic                               s_axi_rvalid,
  input  logic                               s_axi_rready,
  output logic                               irq
);

  rd_state_t state_q, state_d;
  logic                               ar_hs;
  logic [ADDR_WIDTH-1:0]              addr_aligned;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic [1:0]                         rd_resp;
  logic [NUM_STACKS-1:0]              clr_valid;
  logic                               clr_overrun;
  logic [NUM_STACKS*RESULT_WIDTH-1:0] result;
  logic [NUM_STACKS-1:0]              valid;
  logic [NUM_STACKS-1:0]              overrun;
  logic [31:0]                        cap_count;

  cim_done_capture #(
    .NUM_STACKS   (NUM_STACKS),
    .RESULT_WIDTH (RESULT_WIDTH)
  ) u_capture (
    .clk         (clk),
    .reset_n     (reset_n),
    .done        (done),
    .stage_4_out (stage_4_out),
    .clr_valid   (clr_valid),
    .clr_overrun (clr_overrun),
    .result      (result),
    .valid       (valid),
    .overrun     (overrun),
    .cap_count   (cap_count)
  );

  assign addr_aligned = s_axi_araddr & ~ADDR_WIDTH'(3);
  assign irq          = |valid;
  assign s_axi_rvalid = (state_q == RESP);

  // Decode works on pre-update register contents; clears fire only on the
  // handshake cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    rd_data     = '0;
    rd_resp     = RESP_SLVERR;
    clr_valid   = '0;
    clr_overrun = 1'b0;
    if (int'(addr_aligned) == REG_STATUS) begin
      rd_data     = DATA_WIDTH'({16'(overrun), 16'(valid)});
      rd_resp     = RESP_OKAY;
      clr_overrun = ar_hs;
    end else if (int'(addr_aligned) == REG_CAP_COUNT) begin
      rd_data = DATA_WIDTH'(cap_count);
      rd_resp = RESP_OKAY;
    end else begin
      for (int i = 0; i < NUM_STACKS; i++) begin
        if (int'(addr_aligned) == REG_RESULT_BASE + 4 * i) begin
          rd_data      = DATA_WIDTH'($signed(result[i*RESULT_WIDTH +: RESULT_WIDTH]));
          rd_resp      = RESP_OKAY;
          clr_valid[i] = ar_hs;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    s_axi_arready = 1'b0;
    ar_hs         = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          ar_hs   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (s_axi_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        s_axi_rdata <= rd_data;
        s_axi_rresp <= rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_cim_result_reader.sv
// Self-checking bench for cim_result_reader: directed scenarios plus random
// done/read traffic scored against a transaction-level model.
module tb_cim_result_reader;

  localparam int NS = 8;
  localparam int RW = 15;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NS-1:0]     done;
  logic [RW-1:0]     stage [NS];
  logic [NS*RW-1:0]  stage_4_out;
  logic [6:0]        araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic              irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    stage_4_out = '0;
    for (int i = 0; i < NS; i++) stage_4_out[i*RW +: RW] = stage[i];
  end

  cim_result_reader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .done          (done),
    .stage_4_out   (stage_4_out),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .irq           (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_result [NS];
  bit          m_valid [NS];
  bit          m_overrun [NS];
  bit          m_done_q [NS];
  int unsigned m_cap = 0;
  bit          m_idle = 1'b1;
  logic [33:0] exp_q [$];

  function automatic int sext(input logic [RW-1:0] v);
    int x = int'(v);
    if (x >= (1 << (RW - 1))) x -= (1 << RW);
    return x;
  endfunction

  function automatic logic [33:0] model_read(input logic [6:0] addr);
    int a = int'(addr) & ~3;
    logic [31:0] d = '0;
    logic [1:0]  r = 2'b00;
    if (a == 0) begin
      for (int i = 0; i < NS; i++) begin
        d[i]      = m_valid[i];
        d[16 + i] = m_overrun[i];
      end
    end else if (a == 4) d = m_cap;
    else if (a >= 8 && a < 8 + 4 * NS) d = 32'(m_result[(a - 8) / 4]);
    else r = 2'b10;
    return {r, d};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) begin
        m_result[i] = 0; m_valid[i] = 0; m_overrun[i] = 0; m_done_q[i] = 0;
      end
      m_cap  = 0;
      m_idle = 1'b1;
      exp_q.delete();
    end else begin
      bit old_valid [NS];
      int a;
      for (int i = 0; i < NS; i++) old_valid[i] = m_valid[i];
      if (m_idle && arvalid) begin
        exp_q.push_back(model_read(araddr));
        a = int'(araddr) & ~3;
        if (a == 0) for (int i = 0; i < NS; i++) m_overrun[i] = 0;
        else if (a >= 8 && a < 8 + 4 * NS) m_valid[(a - 8) / 4] = 0;
        m_idle = 1'b0;
      end else if (!m_idle && rready) m_idle = 1'b1;
      for (int i = 0; i < NS; i++) begin
        if (done[i] && !m_done_q[i]) begin
          m_overrun[i] = m_overrun[i] | old_valid[i];
          m_valid[i]   = 1'b1;
          m_result[i]  = sext(stage[i]);
          m_cap++;
        end
        m_done_q[i] = done[i];
      end
    end
  end

  function automatic bit any_valid();
    bit v = 0;
    for (int i = 0; i < NS; i++) v |= m_valid[i];
    return v;
  endfunction

  // Per-cycle monitor, sampled mid-period.
  always @(negedge clk) begin
    #1;
    if (reset_n === 1'b1) begin
      logic [33:0] e;
      check("arready", 32'(arready), 32'(m_idle));
      check("rvalid", 32'(rvalid), 32'(!m_idle));
      check("irq", 32'(irq), 32'(any_valid()));
      if (rvalid && rready) begin
        if (exp_q.size() == 0) check("rd_unexpected", 32'(rvalid), 32'(0));
        else begin
          e = exp_q.pop_front();
          check("rdata", rdata, e[31:0]);
          check("rresp", 32'(rresp), 32'(e[33:32]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_read(input logic [6:0] addr, input int hold, input logic [NS-1:0] rise_mask,
                         output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic [31:0] held;
    @(negedge clk);
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b0;
    done    = done | rise_mask;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check("ar_wait", 32'(n < 20), 32'(1));
    @(negedge clk);
    arvalid = 1'b0;
    held = rdata;
    for (int k = 0; k < hold; k++) begin
      check("hold_rvalid", 32'(rvalid), 32'(1));
      check("hold_rdata", rdata, held);
      check("hold_arready", 32'(arready), 32'(0));
      @(negedge clk);
    end
    rready = 1'b1;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check("r_wait", 32'(n < 20), 32'(1));
    data = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic pulse(input int idx, input logic [RW-1:0] val);
    @(negedge clk);
    stage[idx] = val;
    done[idx]  = 1'b1;
    @(negedge clk);
    done[idx]  = 1'b0;
  endtask

  task automatic rand_done_step();
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      if (done[i]) done[i] = ($urandom_range(0, 2) != 0);
      else if ($urandom_range(0, 3) == 0) begin
        stage[i] = RW'($urandom);
        done[i]  = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0]   d;
    logic [1:0]    r;
    logic [NS-1:0] m;
    int            hold;
    logic [6:0]    a;

    done = '0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NS; i++) stage[i] = '0;
    reset_n = 1'b0;
    #1;
    check("rst_arready", 32'(arready), 32'(1));
    check("rst_rvalid", 32'(rvalid), 32'(0));
    check("rst_rdata", rdata, 32'(0));
    check("rst_irq", 32'(irq), 32'(0));
    do_reset();

    // Reset state reads
    do_read(7'h00, 0, '0, d, r); check("status_rst", d, 32'h0); check("status_rst_resp", 32'(r), 32'(0));
    do_read(7'h04, 0, '0, d, r); check("cap_rst", d, 32'h0);
    check("irq_rst", 32'(irq), 32'(0));

    // Single negative capture on stack 3
    pulse(3, 15'h7FF6);
    check("irq_set", 32'(irq), 32'(1));
    do_read(7'h00, 0, '0, d, r); check("status_s3", d, 32'h0000_0008);
    do_read(7'h14, 0, '0, d, r); check("result3_neg", d, 32'hFFFF_FFF6);
    do_read(7'h00, 0, '0, d, r); check("status_clr", d, 32'h0);
    check("irq_clr", 32'(irq), 32'(0));
    do_read(7'h04, 0, '0, d, r); check("cap_one", d, 32'h1);

    // Overrun on stack 0
    pulse(0, 15'd5);
    pulse(0, 15'd9);
    do_read(7'h00, 0, '0, d, r); check("status_ovr", d, 32'h0001_0001);
    do_read(7'h08, 0, '0, d, r); check("result0", d, 32'd9);
    do_read(7'h00, 0, '0, d, r); check("status_ovr_clr", d, 32'h0);

    // Back-pressure on R channel
    do_read(7'h04, 5, '0, d, r); check("cap_hold", d, 32'd3);

    // Unmapped address has no side effects
    pulse(5, 15'd1);
    do_read(7'h40, 0, '0, d, r); check("unmapped_data", d, 32'h0); check("unmapped_resp", 32'(r), 32'(2));
    do_read(7'h00, 0, '0, d, r); check("status_after_unmapped", d, 32'h0000_0020);
    do_read(7'h1C, 0, '0, d, r); check("result5", d, 32'd1);

    // Capture coinciding with a read of the same stack
    pulse(2, 15'd7);
    stage[2] = 15'd12;
    do_read(7'h10, 0, NS'(8'h04), d, r); check("race_old", d, 32'd7);
    done[2] = 1'b0;
    do_read(7'h00, 0, '0, d, r); check("race_status", d, 32'h0004_0004);
    do_read(7'h10, 0, '0, d, r); check("race_new", d, 32'd12);

    // Reset in the middle of a read
    pulse(1, 15'd3);
    @(negedge clk); araddr = 7'h04; arvalid = 1'b1;
    @(negedge clk); arvalid = 1'b0;
    check("midrst_rvalid_pre", 32'(rvalid), 32'(1));
    reset_n = 1'b0;
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'(0));
    check("midrst_irq", 32'(irq), 32'(0));
    @(negedge clk); reset_n = 1'b1;
    do_read(7'h00, 0, '0, d, r); check("midrst_status", d, 32'h0);
    do_read(7'h04, 0, '0, d, r); check("midrst_cap", d, 32'h0);

    // Random traffic, scored by the monitor
    for (int it = 0; it < 200; it++) begin
      repeat ($urandom_range(0, 3)) rand_done_step();
      a = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 'h27)) : 7'($urandom_range(0, 127));
      hold = $urandom_range(0, 2);
      m = '0;
      if ($urandom_range(0, 2) == 0) m = NS'(1 << $urandom_range(0, NS - 1));
      m = m & ~done;
      for (int i = 0; i < NS; i++) if (m[i]) stage[i] = RW'($urandom);
      do_read(a, hold, m, d, r);
    end
    done = '0;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
